// File: rtl/ram_arbiter_pkg.sv
// Purpose : shared types for the instruction/data RAM arbiter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the controller state encoding, the requester identity, and the
// byte-lane count of the default 32-bit word.
package ram_arbiter_pkg;

  localparam int WORD_W = 32;
  localparam int BYTES  = WORD_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_DONE,
    ST_RMW_RD,
    ST_RMW_MERGE,
    ST_WR
  } state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_t;

endpackage

// File: rtl/ram_arbiter_byte_merge.sv
// Purpose : lane-wise merge of a new word into an old word under byte enables.
// Latency : combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   old_word - existing word (e.g. RAM read data)
//   new_word - store data
//   byteen   - lane k selects new_word[8k+7:8k], otherwise old_word lane
//   merged   - resulting word
module byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] byteen,
  output logic [DATA_W-1:0]   merged
);

  always_comb begin
    merged = old_word;
    for (int k = 0; k < DATA_W / 8; k++) begin
      if (byteen[k]) begin
        merged[8*k +: 8] = new_word[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Purpose : shares one single-port word RAM between CPU instruction and data ports.
// Latency : read ack in cycle 2, full store cycle 1, partial store (read-modify-write) cycle 3.
// Backpressure: requests are held until ack; a waiting port is served after at most one foreign transaction.
//
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   i_req/i_addr          - instruction fetch request and byte address
//   i_rdata/i_ack         - fetched word, valid during the one-cycle ack
//   d_read/d_write/d_addr - data request (both high = write) and byte address
//   d_wdata/d_byteen      - store data and per-byte lane enables
//   d_rdata/d_ack         - load word, valid during the one-cycle ack
//   ram_addr/ram_wdata    - word index and write data to the RAM
//   ram_wen               - whole-word write enable
//   ram_rdata             - RAM read data, one cycle after ram_addr
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byteen,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                ram_wen,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int LANES = DATA_W / 8;

  state_t            state;
  port_t             last_grant;
  port_t             grant;
  port_t             pick;
  logic [DATA_W-1:0] wdata_q;
  logic [LANES-1:0]  byteen_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [DATA_W-1:0] merged_w;
  logic [ADDR_W-1:0] i_word;
  logic [ADDR_W-1:0] d_word;
  logic              d_req;
  logic              any_req;
  logic              unused_addr_lsbs;

  // Word index: byte address with the lane bits dropped.
  assign i_word = {2'b00, i_addr[ADDR_W-1:2]};
  assign d_word = {2'b00, d_addr[ADDR_W-1:2]};
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  assign d_req   = d_read | d_write;
  assign any_req = i_req | d_req;

  // Round-robin: on a tie, serve the port that did not win last time.
  always_comb begin
    pick = PORT_I;
    if (i_req && d_req) begin
      pick = (last_grant == PORT_I) ? PORT_D : PORT_I;
    end else if (d_req) begin
      pick = PORT_D;
    end
  end

  // Old word comes straight from the RAM in RMW_MERGE, when ram_rdata is valid.
  byte_merge #(
    .DATA_W (DATA_W)
  ) u_byte_merge (
    .old_word (ram_rdata),
    .new_word (wdata_q),
    .byteen   (byteen_q),
    .merged   (merged_w)
  );

  // The RAM read data is valid in RD_DONE, the same cycle as the ack, so the
  // output bypasses the capture register during the ack cycle.
  assign i_rdata = i_ack ? ram_rdata : i_rdata_q;
  assign d_rdata = d_ack ? ram_rdata : d_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= PORT_I;
      grant      <= PORT_I;
      wdata_q    <= '0;
      byteen_q   <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      ram_wen    <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      // Acks and write enable are single-cycle pulses.
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      ram_wen <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant      <= pick;
            last_grant <= pick;
            ram_addr   <= (pick == PORT_I) ? i_word : d_word;
            wdata_q    <= d_wdata;
            byteen_q   <= d_byteen;
            // d_write wins over d_read when both are raised.
            if (pick == PORT_D && d_write) begin
              if (d_byteen == '1) begin
                state     <= ST_WR;
                ram_wen   <= 1'b1;
                ram_wdata <= d_wdata;
                d_ack     <= 1'b1;
              end else if (d_byteen == '0) begin
                // Empty store: complete without touching the RAM.
                state <= ST_WR;
                d_ack <= 1'b1;
              end else begin
                state <= ST_RMW_RD;
              end
            end else begin
              state <= ST_RD;
            end
          end
        end

        ST_RD: begin
          state <= ST_RD_DONE;
          if (grant == PORT_I) begin
            i_ack <= 1'b1;
          end else begin
            d_ack <= 1'b1;
          end
        end

        ST_RD_DONE: begin
          if (grant == PORT_I) begin
            i_rdata_q <= ram_rdata;
          end else begin
            d_rdata_q <= ram_rdata;
          end
          ram_addr <= '0;
          state    <= ST_IDLE;
        end

        ST_RMW_RD: begin
          state <= ST_RMW_MERGE;
        end

        ST_RMW_MERGE: begin
          state     <= ST_WR;
          ram_wdata <= merged_w;
          ram_wen   <= |byteen_q;
          d_ack     <= 1'b1;
        end

        ST_WR: begin
          ram_addr <= '0;
          state    <= ST_IDLE;
        end

        default: begin
          ram_addr <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Purpose : directed self-checking bench for ram_arbiter with a behavioural RAM.
// Latency : n/a.
// Backpressure: n/a.
module tb_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteen;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wen;
  logic [31:0] ram_rdata;

  int checks;
  int failures;

  // Behavioural synchronous RAM: 16 words, read data one cycle after address.
  logic [31:0] mem [0:15];
  logic        bd_we;
  logic [3:0]  bd_addr;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (ram_wen) begin
      mem[ram_addr[3:0]] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr[3:0]];
  end

  ram_arbiter #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_byteen  (d_byteen),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wen   (ram_wen),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = v;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_i_ack"},     {31'd0, i_ack},   32'd0);
    check({tag, "_d_ack"},     {31'd0, d_ack},   32'd0);
    check({tag, "_ram_wen"},   {31'd0, ram_wen}, 32'd0);
    check({tag, "_ram_addr"},  ram_addr,         32'd0);
    check({tag, "_ram_wdata"}, ram_wdata,        32'd0);
    check({tag, "_i_rdata"},   i_rdata,          32'd0);
    check({tag, "_d_rdata"},   d_rdata,          32'd0);
  endtask

  task automatic drop_requests();
    i_req    = 1'b0;
    d_read   = 1'b0;
    d_write  = 1'b0;
    i_addr   = 32'd0;
    d_addr   = 32'd0;
    d_wdata  = 32'd0;
    d_byteen = 4'd0;
  endtask

  // One transaction from a single requester. Entered just after a negedge.
  // exp_data is the read word for loads, the RAM write data for stores.
  task automatic txn(input string tag, input logic is_i, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                     input int exp_lat, input int exp_wen, input logic chk_data,
                     input logic [31:0] exp_data);
    int          lat;
    int          wen_cnt;
    int          extra;
    logic        got;
    logic [31:0] addr_c1;
    logic [31:0] data_at_ack;
    lat = 0; wen_cnt = 0; extra = 0; got = 1'b0;
    addr_c1 = 32'hFFFF_FFFF; data_at_ack = 32'h0;
    i_req = is_i; i_addr = addr;
    d_read = rd; d_write = wr; d_addr = addr; d_wdata = wd; d_byteen = be;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (ram_wen) wen_cnt++;
      if (lat == 1) addr_c1 = ram_addr;
      if (is_i ? i_ack : d_ack) begin
        got = 1'b1;
        data_at_ack = (wr) ? ram_wdata : (is_i ? i_rdata : d_rdata);
      end
    end
    drop_requests();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (i_ack || d_ack) extra++;
      if (ram_wen) wen_cnt++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_ram_addr"}, addr_c1, {2'b00, addr[31:2]});
    check({tag, "_wen_count"}, 32'(wen_cnt), 32'(exp_wen));
    check({tag, "_extra_ack"}, 32'(extra), 32'd0);
    if (chk_data) check({tag, "_data"}, data_at_ack, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ack_cycle [0:7];
    logic        ack_port  [0:7];
    logic [31:0] ack_data  [0:7];
    int          n_acks;
    int          both_cnt;
    int          bad_cnt;

    checks = 0; failures = 0;
    reset = 1'b1;
    bd_we = 1'b0; bd_addr = 4'd0; bd_data = 32'd0;
    drop_requests();

    for (int w = 0; w < 16; w++) bd_write(4'(w), 32'd0);
    bd_write(4'd1, 32'hDEADBEEF);
    bd_write(4'd3, 32'hAABBCCDD);
    bd_write(4'd5, 32'h55667788);

    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single-requester traffic.
    txn("iread",   1, 0, 0, 32'd4,  32'd0,         4'h0, 2, 0, 1, 32'hDEADBEEF);
    txn("fstore",  0, 0, 1, 32'd8,  32'h12345678,  4'hF, 1, 1, 1, 32'h12345678);
    txn("fload",   0, 1, 0, 32'd8,  32'd0,         4'h0, 2, 0, 1, 32'h12345678);
    txn("pstore",  0, 0, 1, 32'd12, 32'h11223344,  4'h5, 3, 1, 1, 32'hAA22CC44);
    txn("pload",   0, 1, 0, 32'd12, 32'd0,         4'h0, 2, 0, 1, 32'hAA22CC44);
    txn("be0",     0, 0, 1, 32'd8,  32'hFFFFFFFF,  4'h0, 1, 0, 0, 32'd0);
    txn("be0load", 0, 1, 0, 32'd8,  32'd0,         4'h0, 2, 0, 1, 32'h12345678);
    txn("rdwr",    0, 1, 1, 32'd16, 32'hCAFEF00D,  4'hF, 1, 1, 1, 32'hCAFEF00D);
    txn("rdwrld",  0, 1, 0, 32'd16, 32'd0,         4'h0, 2, 0, 1, 32'hCAFEF00D);
    txn("iread2",  1, 0, 0, 32'd7,  32'd0,         4'h0, 2, 0, 1, 32'hDEADBEEF);

    // Contention from reset: both ports held; data wins the first tie.
    reset = 1'b1;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'd4;
    d_read = 1'b1; d_addr = 32'd8;
    @(negedge clk);
    reset = 1'b0;
    n_acks = 0; both_cnt = 0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (i_ack && d_ack) both_cnt++;
      if ((i_ack || d_ack) && n_acks < 8) begin
        ack_cycle[n_acks] = k;
        ack_port[n_acks]  = d_ack;
        ack_data[n_acks]  = d_ack ? d_rdata : i_rdata;
        n_acks++;
      end
    end
    check("cont_ack_count", 32'(n_acks), 32'd4);
    check("cont_both_acks", 32'(both_cnt), 32'd0);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("cont%0d_cycle", j), 32'(ack_cycle[j]), 32'(2 + 3 * j));
      check($sformatf("cont%0d_port_is_d", j), {31'd0, ack_port[j]}, {31'd0, (j % 2) == 0});
      check($sformatf("cont%0d_data", j), ack_data[j],
            ((j % 2) == 0) ? 32'h12345678 : 32'hDEADBEEF);
    end
    reset = 1'b1;
    drop_requests();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset while in RMW_MERGE: the store must be abandoned.
    d_write = 1'b1; d_addr = 32'd20; d_wdata = 32'h11223344; d_byteen = 4'b0011;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    drop_requests();
    @(negedge clk);
    check_reset_outputs("rmw_reset");
    reset = 1'b0;
    bad_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ram_wen || d_ack || i_ack) bad_cnt++;
    end
    check("rmw_reset_quiet", 32'(bad_cnt), 32'd0);
    txn("rmw_after", 0, 1, 0, 32'd20, 32'd0, 4'h0, 2, 0, 1, 32'h55667788);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
